// File: rtl/encryption.sv
`default_nettype none
// ============================================================================
// Module      : encryption
// Description : Iterative AES-128 encryption core. One round per clock, round
//               keys expanded on the fly, 10 cycles from start to valid_flag.
//               Optional macro ENCRYPTION_BUSY_EN adds a 'busy' status output.
// Revision    : 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// encryption_sbox : combinational AES forward S-box (table lookup, no RAM)
// ----------------------------------------------------------------------------
module encryption_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    localparam logic [7:0] SBOX_TABLE [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TABLE[in_byte];

endmodule

// ----------------------------------------------------------------------------
// encryption : top level
// Byte i of any 128-bit bus occupies bits [8*i : 8*i+7], bit 8*i being its MSB.
// AES state byte i sits in column i/4, row i%4.
// ----------------------------------------------------------------------------
module encryption (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] key,
    input  logic [0:127] plain_text,
    output logic [0:127] enc_data,
    output logic         valid_flag
`ifdef ENCRYPTION_BUSY_EN
    ,
    output logic         busy
`endif
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } fsm_t;

    localparam logic [3:0] LAST_ROUND = 4'd10;

    fsm_t         fsm_q,        fsm_d;
    logic [0:127] state_q,      state_d;
    logic [0:127] round_key_q,  round_key_d;
    logic [3:0]   round_q,      round_d;
    logic [0:127] enc_data_q,   enc_data_d;
    logic         valid_flag_q, valid_flag_d;

    logic [0:127] sub_bytes;
    logic [0:127] shifted;
    logic [0:127] mixed;
    logic [0:31]  key_sub;
    logic [0:31]  key_temp;
    logic [0:127] next_key;
    logic [0:127] round_out;

    // Multiply by x in GF(2^8) modulo the AES polynomial
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One MixColumns column; col[31:24] is row 0
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    // Round constant for the key expanded during round 'rnd'
    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    // SubBytes on the data path: one S-box per state byte
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_data_sbox
            encryption_sbox u_sbox (
                .in_byte  (state_q[8*gi +: 8]),
                .out_byte (sub_bytes[8*gi +: 8])
            );
        end
    endgenerate

    // SubWord(RotWord(w3)) for the key schedule: bytes 13,14,15,12
    genvar gk;
    generate
        for (gk = 0; gk < 4; gk++) begin : g_key_sbox
            encryption_sbox u_sbox (
                .in_byte  (round_key_q[8*(12 + ((gk + 1) % 4)) +: 8]),
                .out_byte (key_sub[8*gk +: 8])
            );
        end
    endgenerate

    // Round datapath: ShiftRows, MixColumns (skipped in the last round), key expansion, AddRoundKey
    always_comb begin
        shifted   = '0;
        mixed     = '0;
        key_temp  = '0;
        next_key  = '0;
        round_out = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                shifted[8*(4*c + r) +: 8] = sub_bytes[8*(4*((c + r) % 4) + r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[32*c +: 32] = mix_column(shifted[32*c +: 32]);
        end
        key_temp           = key_sub ^ {rcon(round_q), 24'h000000};
        next_key[0  +: 32] = round_key_q[0  +: 32] ^ key_temp;
        next_key[32 +: 32] = round_key_q[32 +: 32] ^ next_key[0  +: 32];
        next_key[64 +: 32] = round_key_q[64 +: 32] ^ next_key[32 +: 32];
        next_key[96 +: 32] = round_key_q[96 +: 32] ^ next_key[64 +: 32];
        round_out = ((round_q == LAST_ROUND) ? shifted : mixed) ^ next_key;
    end

    // Control FSM: IDLE samples start and loads inputs; BUSY runs one round per cycle
    always_comb begin
        fsm_d        = fsm_q;
        state_d      = state_q;
        round_key_d  = round_key_q;
        round_d      = round_q;
        enc_data_d   = enc_data_q;
        valid_flag_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    state_d     = plain_text ^ key;
                    round_key_d = key;
                    round_d     = 4'd1;
                    fsm_d       = BUSY;
                end
            end
            BUSY: begin
                state_d     = round_out;
                round_key_d = next_key;
                round_d     = round_q + 4'd1;
                if (round_q == LAST_ROUND) begin
                    enc_data_d   = round_out;
                    valid_flag_d = 1'b1;
                    round_d      = 4'd0;
                    fsm_d        = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q        <= IDLE;
            state_q      <= '0;
            round_key_q  <= '0;
            round_q      <= '0;
            enc_data_q   <= '0;
            valid_flag_q <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            state_q      <= state_d;
            round_key_q  <= round_key_d;
            round_q      <= round_d;
            enc_data_q   <= enc_data_d;
            valid_flag_q <= valid_flag_d;
        end
    end

    assign enc_data   = enc_data_q;
    assign valid_flag = valid_flag_q;

`ifdef ENCRYPTION_BUSY_EN
    assign busy = (fsm_q == BUSY);
`endif

endmodule

`default_nettype wire

// File: tb/tb_encryption.sv
`default_nettype none
// ============================================================================
// Module      : tb_encryption
// Description : Scoreboard bench for the AES-128 encryption core. Expected
//               ciphertexts and pulse times are queued at each start edge and
//               checked by an independent monitor on the falling clock edge.
//               Honours ENCRYPTION_BUSY_EN to check the optional busy output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encryption;

    logic         clock;
    logic         reset;
    logic         start;
    logic [0:127] key;
    logic [0:127] plain_text;
    logic [0:127] enc_data;
    logic         valid_flag;
`ifdef ENCRYPTION_BUSY_EN
    logic         busy;
`endif

    encryption dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .plain_text (plain_text),
        .enc_data   (enc_data),
        .valid_flag (valid_flag)
`ifdef ENCRYPTION_BUSY_EN
        ,
        .busy       (busy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [0:127] data;
        int           cyc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_vec   = 0;
    int         n_bad   = 0;
    int         neg_cnt = 0;
    logic [7:0] sbox_tab [0:255];

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = (v << n) | (v >> (8 - n));
        return r;
    endfunction

    // S-box derived from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] xv;
        logic [7:0] yv;
        for (int x = 0; x < 256; x++) begin
            xv  = x[7:0];
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                yv = y[7:0];
                if (gmul(xv, yv) == 8'h01) inv = yv;
            end
            sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [0:127] aes_ref(input logic [0:127] pt, input logic [0:127] k);
        logic [7:0]   w [0:175];
        logic [7:0]   s [0:15];
        logic [7:0]   t [0:15];
        logic [7:0]   tmp [0:3];
        logic [7:0]   t0, rc, a0, a1, a2, a3;
        logic [0:127] res;
        for (int i = 0; i < 16; i++) w[i] = k[8*i +: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[4*(i-1) + j];
            if (i % 4 == 0) begin
                t0     = tmp[0];
                tmp[0] = sbox_tab[tmp[1]] ^ rc;
                tmp[1] = sbox_tab[tmp[2]];
                tmp[2] = sbox_tab[tmp[3]];
                tmp[3] = sbox_tab[t0];
                rc     = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
            for (int c = 0; c < 4; c++)
                for (int rr = 0; rr < 4; rr++)
                    t[4*c + rr] = s[4*((c + rr) % 4) + rr];
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
        end
        for (int i = 0; i < 16; i++) res[8*i +: 8] = s[i];
        return res;
    endfunction

    function automatic logic [0:127] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            neg_cnt++;
            if (valid_flag) begin
                if (sb_q.size() == 0) begin
                    n_vec++; n_bad++;
                    $display("FAIL unexpected_valid: valid_flag=1 at cycle %0d, required 0", neg_cnt);
                end else begin
                    e = sb_q.pop_front();
                    n_vec++;
                    if (enc_data !== e.data) begin
                        n_bad++;
                        $display("FAIL enc_data: got %h, required %h", enc_data, e.data);
                    end
                    n_vec++;
                    if (neg_cnt != e.cyc) begin
                        n_bad++;
                        $display("FAIL valid_timing: pulse at cycle %0d, required %0d", neg_cnt, e.cyc);
                    end
                end
            end else if (sb_q.size() > 0 && neg_cnt >= sb_q[0].cyc) begin
                e = sb_q.pop_front();
                n_vec++; n_bad++;
                $display("FAIL missing_valid: no pulse by cycle %0d, required at %0d (data %h)", neg_cnt, e.cyc, e.data);
            end
`ifdef ENCRYPTION_BUSY_EN
            begin
                logic exp_busy;
                exp_busy = (sb_q.size() > 0) && (neg_cnt >= sb_q[0].cyc - 10) && (neg_cnt < sb_q[0].cyc);
                n_vec++;
                if (busy !== exp_busy) begin
                    n_bad++;
                    $display("FAIL busy: got %b at cycle %0d, required %b", busy, neg_cnt, exp_busy);
                end
            end
`endif
        end
    end

    // ---------------- stimulus ----------------
    // mode 0: quiet while busy; 1: random inputs/start while busy; 2: one extra start pulse 3 cycles in
    task automatic run_block(input logic [0:127] pt, input logic [0:127] k,
                             input logic [0:127] exp_data, input int mode);
        exp_t e;
        @(negedge clock);
        plain_text = pt;
        key        = k;
        start      = 1'b1;
        @(posedge clock);
        e.data = exp_data;
        e.cyc  = neg_cnt + 11;
        sb_q.push_back(e);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            start = 1'b0;
            if (mode == 1) begin
                start      = 1'($urandom_range(0, 1));
                plain_text = rand128();
                key        = rand128();
            end else if (mode == 2 && i == 3) begin
                start      = 1'b1;
                plain_text = rand128();
                key        = rand128();
            end
        end
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        n_vec++;
        if (enc_data !== 128'h0) begin
            n_bad++;
            $display("FAIL %s_enc_data: got %h, required 0", tag, enc_data);
        end
        n_vec++;
        if (valid_flag !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_valid_flag: got %b, required 0", tag, valid_flag);
        end
    endtask

    initial begin
        logic [0:127] pt, k;
        exp_t         e;
        build_sbox();
        reset      = 1'b0;
        start      = 1'b0;
        key        = '0;
        plain_text = '0;
        #2 reset = 1'b1;
        #1 check_zero_outputs("reset");
        repeat (2) @(negedge clock);
        reset = 1'b0;

        run_block(128'h00000101030307070f0f1f1f3f3f7f7f, 128'h0,
                  128'hc7d12419489e3b6233a2c5a7f4563172, 0);
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);
        run_block(128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, 2);

        // Abort mid-operation with reset
        @(negedge clock);
        plain_text = 128'h00112233445566778899aabbccddeeff;
        key        = 128'h000102030405060708090a0b0c0d0e0f;
        start      = 1'b1;
        @(posedge clock);
        e.data = 128'h0;
        e.cyc  = neg_cnt + 11;
        sb_q.push_back(e);
        @(negedge clock);
        start = 1'b0;
        repeat (4) @(posedge clock);
        #2 reset = 1'b1;
        sb_q.delete();
        #1 check_zero_outputs("abort");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        run_block(128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

        // start held high across two blocks
        pt = rand128();
        k  = rand128();
        @(negedge clock);
        plain_text = pt;
        key        = k;
        start      = 1'b1;
        @(posedge clock);
        e.data = aes_ref(pt, k);
        e.cyc  = neg_cnt + 11;
        sb_q.push_back(e);
        e.cyc  = neg_cnt + 22;
        sb_q.push_back(e);
        repeat (11) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (11) @(negedge clock);

        // Randomized blocks, some with input noise while busy
        for (int n = 0; n < 12; n++) begin
            pt = rand128();
            k  = rand128();
            run_block(pt, k, aes_ref(pt, k), n % 2);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Drain: bounded wait, the monitor reports any expectation left unserved
        for (int i = 0; i < 30 && sb_q.size() > 0; i++) @(negedge clock);
        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/encryption.md
ENCRYPTION -- requirements
Module: encryption

Interface
REQ-001 The interface SHALL be: one clock; reset is asynchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request to begin one AES-128 encryption; sampled only in IDLE.
REQ-005 key  input  128 [0:127]  cipher key; bit 0 is the MSB of byte 0 (FIPS-197 byte order).
REQ-006 plain_text  input  128 [0:127]  plaintext block, same bit/byte order as key.
REQ-007 enc_data  output  128 [0:127]  registered ciphertext, same order.
REQ-008 valid_flag  output  1  registered one-cycle pulse marking a new enc_data value.

Function
REQ-009 The block SHALL compute AES-128 encryption per FIPS-197: 10 rounds, with SubBytes, ShiftRows, MixColumns and AddRoundKey, and MixColumns omitted in round 10.
REQ-010 FSM SHALL have two states: IDLE and BUSY; reset enters IDLE.
REQ-011 IDLE, start=1 at edge N: state register SHALL load plain_text XOR key, round-key register SHALL load key, round counter SHALL load 1, FSM SHALL go to BUSY; key/plain_text SHALL NOT be sampled again.
REQ-012 BUSY: each edge SHALL perform exactly one round, with the round key expanded on the fly from the previous round key and Rcon (01,02,04,08,10,20,40,80,1B,36); no key-schedule storage.
REQ-013 Round 10 completes at edge N+10: enc_data SHALL load the result, valid_flag SHALL be 1 for the cycle after N+10 only, and the FSM SHALL return to IDLE. Start-to-valid latency is 10 cycles; the throughput is one block per 11 cycles.
REQ-014 start held high continuously SHALL restart the block at edge N+11, the first IDLE edge.
REQ-015 start while BUSY SHALL be ignored; input changes while BUSY SHALL NOT affect the result.
REQ-016 enc_data SHALL hold its last value until the next completion; valid_flag SHALL be 0 at all other times.
REQ-017 S-box SHALL be combinational: 16 instances for data and 4 for the key schedule; no RAM.

Reset
REQ-018 reset=1 SHALL immediately force enc_data=0, valid_flag=0, the state, round-key and counter registers to 0, and the FSM to IDLE.
REQ-019 Reset mid-operation SHALL abort the encryption with no valid_flag pulse; the first start after reset deassertion SHALL behave per REQ-011.

Configuration
REQ-020 Macro ENCRYPTION_BUSY_EN defined: the block SHALL add output busy (1 bit, reset 0), which is high exactly while the FSM is in BUSY, i.e. from after edge N through edge N+10.
REQ-021 Macro undefined: no busy port; all other behaviour is identical.

Verification
REQ-022 Reset, then start=1 with plain_text=00000101030307070f0f1f1f3f3f7f7f and key=0: enc_data SHALL be c7d12419489e3b6233a2c5a7f4563172, and valid_flag SHALL pulse 10 cycles after the start edge.
REQ-023 plain_text=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f -> enc_data=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-024 plain_text=3243f6a8885a308d313198a2e0370734, key=2b7e151628aed2a6abf7158809cf4f3c -> enc_data=3925841d02dc09fbdc118597196a0b32; then change key/plain_text and pulse start 3 cycles after the start edge -> the same result, no extra valid_flag.
REQ-025 Assert reset 5 cycles after start -> enc_data=0 and valid_flag=0 immediately, no pulse; after release, a start with the REQ-023 vector -> the correct result after 10 cycles.
REQ-026 start held high over two blocks -> valid_flag pulses 11 cycles apart; with ENCRYPTION_BUSY_EN, busy is high for 10 cycles per block.
